wbc_rr_intercon: RTL and testbench

//  Parametrised WISHBONE control-bus shared-bus interconnect: NM masters, NS slaves.

---
 rtl/wbc_rr_intercon_pkg.sv | 33 +++
 rtl/wb_rr_arbiter.sv | 49 ++++
 rtl/wbc_rr_intercon.sv | 198 +++++++++++++++++++
 tb/tb_wbc_rr_intercon.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbc_rr_intercon_pkg.sv
// Shared types for the WISHBONE control-bus round-robin interconnect.
// Holds the bus-owner FSM states, the slave response encoding and the
// helper that resolves simultaneous response lines (err > rty > ack).
package wbc_rr_intercon_pkg;

    // Width of the per-transfer ack-timeout counter
    localparam int unsigned TMO_CW = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_ACK  = 2'd1,
        RSP_RTY  = 2'd2,
        RSP_ERR  = 2'd3
    } rsp_e;

    // Collapse raw response lines to a single response, err winning over rty over ack
    function automatic rsp_e rsp_prio(input logic ack, input logic err, input logic rty);
        if (err) begin
            return RSP_ERR;
        end else if (rty) begin
            return RSP_RTY;
        end else if (ack) begin
            return RSP_ACK;
        end
        return RSP_NONE;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin request picker for the control-bus interconnect.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   req_i         per-master request (cyc)
//   gnt_en_i      a grant is being taken this cycle; advance the pointer
//   winner_o      one-hot first requester at/after (last_owner+1) mod NM
module wb_rr_arbiter #(
    parameter int unsigned NM = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [NM-1:0] req_i,
    input  logic          gnt_en_i,
    output logic [NM-1:0] winner_o
);

    localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;

    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] win_idx;

    // Scan from lowest priority to highest so the last hit written is the winner
    always_comb begin : p_pick
        logic [IW-1:0] idx;
        idx      = '0;
        winner_o = '0;
        win_idx  = last_q;
        for (int unsigned k = NM; k >= 1; k--) begin
            idx = IW'((32'(last_q) + k) % NM);
            if (req_i[idx]) begin
                winner_o      = '0;
                winner_o[idx] = 1'b1;
                win_idx       = idx;
            end
        end
    end

    assign last_d = (gnt_en_i && (|req_i)) ? win_idx : last_q;

    // Reset pointer to the last master so master 0 starts with top priority
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= IW'(NM - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/wbc_rr_intercon.sv
// WISHBONE control-bus shared-bus interconnect, NM masters to NS slaves.
// Round-robin arbitration with cyc-held bus lock, mask/base decode (lowest
// hit wins), registered err on unmapped addresses, per-transfer ack timeout.
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i/m_adr_i/...   flattened master requests
//   m_ack_o/m_err_o/m_rty_o              responses, owner only
//   m_dat_o                              read data, shared
//   s_cyc_o/s_stb_o                      to decoded slave only
//   s_we_o/s_adr_o/s_dat_o/s_sel_o       owner's request, shared
//   s_ack_i/s_err_i/s_rty_i/s_dat_i      slave responses
//   grant_o                              one-hot owner, 0 when idle
//   timeout_o                            pulse when a timeout err is issued
module wbc_rr_intercon
    import wbc_rr_intercon_pkg::*;
#(
    parameter int unsigned       NM       = 3,
    parameter int unsigned       NS       = 4,
    parameter int unsigned       DW       = 32,
    parameter int unsigned       AW       = 20,
    parameter logic [NS*AW-1:0]  SLV_BASE = '0,
    parameter logic [NS*AW-1:0]  SLV_MASK = '0,
    parameter int unsigned       TIMEOUT  = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NM-1:0]          m_cyc_i,
    input  logic [NM-1:0]          m_stb_i,
    input  logic [NM-1:0]          m_we_i,
    input  logic [NM*AW-1:0]       m_adr_i,
    input  logic [NM*DW-1:0]       m_dat_i,
    input  logic [NM*(DW/8)-1:0]   m_sel_i,
    output logic [NM-1:0]          m_ack_o,
    output logic [NM-1:0]          m_err_o,
    output logic [NM-1:0]          m_rty_o,
    output logic [DW-1:0]          m_dat_o,
    output logic [NS-1:0]          s_cyc_o,
    output logic [NS-1:0]          s_stb_o,
    output logic                   s_we_o,
    output logic [AW-1:0]          s_adr_o,
    output logic [DW-1:0]          s_dat_o,
    output logic [(DW/8)-1:0]      s_sel_o,
    input  logic [NS-1:0]          s_ack_i,
    input  logic [NS-1:0]          s_err_i,
    input  logic [NS-1:0]          s_rty_i,
    input  logic [NS*DW-1:0]       s_dat_i,
    output logic [NM-1:0]          grant_o,
    output logic                   timeout_o
);

    localparam int unsigned SW = DW / 8;

    state_e            state_q, state_d;
    logic [NM-1:0]     grant_q, grant_d;
    logic [TMO_CW-1:0] cnt_q, cnt_d;
    logic              unm_q, unm_d;
    logic [NM-1:0]     winner;
    logic              arb_en;

    logic              own_cyc, own_stb, own_we;
    logic [AW-1:0]     own_adr;
    logic [DW-1:0]     own_dat;
    logic [SW-1:0]     own_sel;

    logic [NS-1:0]     hit, sel_oh;
    logic              any_hit, active, valid;
    logic              sl_ack, sl_err, sl_rty, sl_any, tmo_fire;
    logic [DW-1:0]     sl_dat;
    rsp_e              rsp;

    wb_rr_arbiter #(.NM(NM)) u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (m_cyc_i),
        .gnt_en_i (arb_en),
        .winner_o (winner)
    );

    // Route the granted master's request; all zero when nobody owns the bus
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        for (int m = 0; m < NM; m++) begin
            if (grant_q[m]) begin
                own_cyc = m_cyc_i[m];
                own_stb = m_stb_i[m];
                own_we  = m_we_i[m];
                own_adr = m_adr_i[m*AW +: AW];
                own_dat = m_dat_i[m*DW +: DW];
                own_sel = m_sel_i[m*SW +: SW];
            end
        end
    end

    // Address decode; isolate the lowest set hit bit to resolve overlaps
    always_comb begin
        hit = '0;
        for (int s = 0; s < NS; s++) begin
            hit[s] = ((own_adr & SLV_MASK[s*AW +: AW]) == SLV_BASE[s*AW +: AW]);
        end
    end

    assign sel_oh  = hit & (~hit + NS'(1));
    assign any_hit = |hit;
    assign active  = (state_q == ST_OWN) && own_cyc;
    assign valid   = active && own_stb && any_hit;

    // Selected slave response and read data
    always_comb begin
        sl_dat = '0;
        for (int s = 0; s < NS; s++) begin
            if (sel_oh[s]) begin
                sl_dat = s_dat_i[s*DW +: DW];
            end
        end
    end

    assign sl_ack = |(s_ack_i & sel_oh);
    assign sl_err = |(s_err_i & sel_oh);
    assign sl_rty = |(s_rty_i & sel_oh);
    assign sl_any = sl_ack || sl_err || sl_rty;

    // cnt_q holds prior unanswered stb cycles, so +1 counts the current one
    assign tmo_fire = valid && !sl_any && ((32'(cnt_q) + 32'd1) == TIMEOUT);

    assign rsp = rsp_prio(valid && sl_ack,
                          (valid && sl_err) || tmo_fire || unm_q,
                          valid && sl_rty);

    assign m_ack_o   = (rsp == RSP_ACK) ? grant_q : '0;
    assign m_rty_o   = (rsp == RSP_RTY) ? grant_q : '0;
    assign m_err_o   = (rsp == RSP_ERR) ? grant_q : '0;
    assign m_dat_o   = (active && any_hit) ? sl_dat : '0;
    assign s_cyc_o   = (active && any_hit) ? sel_oh : '0;
    assign s_stb_o   = (valid && !tmo_fire) ? sel_oh : '0;
    assign s_we_o    = own_we;
    assign s_adr_o   = own_adr;
    assign s_dat_o   = own_dat;
    assign s_sel_o   = own_sel;
    assign grant_o   = grant_q;
    assign timeout_o = tmo_fire;

    // Bus ownership FSM; dropping back to IDLE forces one dead cycle
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        arb_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|m_cyc_i) begin
                    state_d = ST_OWN;
                    grant_d = winner;
                    arb_en  = 1'b1;
                end
            end
            ST_OWN: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Timeout counter runs only while a mapped strobe waits for an answer
    always_comb begin
        cnt_d = '0;
        if (valid && !sl_any && !tmo_fire && (grant_d == grant_q)) begin
            cnt_d = cnt_q + TMO_CW'(1);
        end
    end

    // Unmapped err is suppressed right after firing so it stays a single pulse
    assign unm_d = active && own_stb && !any_hit && !unm_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
            unm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            unm_q   <= unm_d;
        end
    end

endmodule

// File: tb/tb_wbc_rr_intercon.sv
// Self-checking bench for wbc_rr_intercon: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_wbc_rr_intercon;

    localparam int unsigned NM  = 3;
    localparam int unsigned NS  = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 20;
    localparam int unsigned SW  = 4;
    localparam int unsigned TMO = 255;

    // Slave 0..3 windows; slave 2 (0x20000-0x3FFFF) overlaps slave 3 (0x38000-0x3FFFF)
    localparam logic [NS*AW-1:0] BASE = {20'h38000, 20'h20000, 20'h10000, 20'h00000};
    localparam logic [NS*AW-1:0] MASK = {20'hF8000, 20'hE0000, 20'hF0000, 20'hF0000};

    logic [AW-1:0] ref_base [NS] = '{20'h00000, 20'h10000, 20'h20000, 20'h38000};
    logic [AW-1:0] ref_mask [NS] = '{20'hF0000, 20'hF0000, 20'hE0000, 20'hF8000};

    logic clk = 1'b0;
    logic rst;
    logic [NM-1:0]    m_cyc, m_stb, m_we;
    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_dat;
    logic [NM*SW-1:0] m_sel;
    logic [NM-1:0]    m_ack, m_err, m_rty;
    logic [DW-1:0]    mdat_out;
    logic [NS-1:0]    s_cyc, s_stb;
    logic             s_we;
    logic [AW-1:0]    s_adr;
    logic [DW-1:0]    sdat_out;
    logic [SW-1:0]    ssel_out;
    logic [NS-1:0]    s_ack, s_err, s_rty;
    logic [NS*DW-1:0] sdat_in;
    logic [NM-1:0]    grant;
    logic             tmo;

    int n_vec;
    int n_err;

    always #5 clk = ~clk;

    wbc_rr_intercon #(
        .NM(NM), .NS(NS), .DW(DW), .AW(AW),
        .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty), .m_dat_o(mdat_out),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
        .s_dat_o(sdat_out), .s_sel_o(ssel_out),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .s_dat_i(sdat_in),
        .grant_o(grant), .timeout_o(tmo)
    );

    function automatic int ref_decode(input logic [AW-1:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & ref_mask[i]) == ref_base[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        s_ack = '0; s_err = '0; s_rty = '0; sdat_in = '0;
    endtask

    task automatic set_m(input int m, input logic cyc, input logic stb, input logic [AW-1:0] adr);
        m_cyc[m] = cyc;
        m_stb[m] = stb;
        m_adr[m*AW +: AW] = adr;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs;
        m_cyc = '1; m_stb = '1; s_ack = '1;
        tick;
        tick;
        #1;
        n_vec++;
        if ({grant, m_ack, m_err, m_rty, tmo} !== '0) begin
            n_err++;
            $display("FAIL reset_master_side: got %b want 0", {grant, m_ack, m_err, m_rty, tmo});
        end
        n_vec++;
        if ({s_cyc, s_stb, mdat_out, s_adr} !== '0) begin
            n_err++;
            $display("FAIL reset_slave_side: got %h want 0", {s_cyc, s_stb, mdat_out, s_adr});
        end
        clear_inputs;
    endtask

    task automatic test_single;
        do_reset;
        set_m(0, 1'b1, 1'b1, 20'h00010);
        m_we[0] = 1'b1; m_dat[31:0] = 32'hDEADBEEF; m_sel[3:0] = 4'hF;
        #1;
        n_vec++;
        if ({grant, s_stb} !== 7'b0) begin
            n_err++; $display("FAIL single_pre_grant: got %b want 0", {grant, s_stb});
        end
        tick;
        s_ack[0] = 1'b1; sdat_in[31:0] = 32'h12345678;
        #1;
        n_vec++;
        if ({grant, m_ack, s_cyc, s_stb} !== {3'b001, 3'b001, 4'b0001, 4'b0001}) begin
            n_err++; $display("FAIL single_grant_ack: got %b want 001_001_0001_0001", {grant, m_ack, s_cyc, s_stb});
        end
        n_vec++;
        if ({s_we, s_adr, sdat_out, ssel_out, mdat_out} !== {1'b1, 20'h00010, 32'hDEADBEEF, 4'hF, 32'h12345678}) begin
            n_err++; $display("FAIL single_route: got %h", {s_we, s_adr, sdat_out, ssel_out, mdat_out});
        end
        tick;
        set_m(0, 1'b0, 1'b0, 20'h0); s_ack = '0;
        #1;
        n_vec++;
        if ({grant, m_ack, s_cyc} !== {3'b001, 3'b000, 4'b0000}) begin
            n_err++; $display("FAIL single_release: got %b want 001_000_0000", {grant, m_ack, s_cyc});
        end
        tick;
        #1;
        n_vec++;
        if (grant !== 3'b000) begin
            n_err++; $display("FAIL single_idle: got %b want 000", grant);
        end
    endtask

    task automatic test_decode;
        logic [AW-1:0] dec_adr [6] = '{20'h00000, 20'h1ABCD, 20'h2FFFF, 20'h38004, 20'h3FFFF, 20'h50000};
        int            dec_exp [6] = '{0, 1, 2, 2, 2, -1};
        logic [NS-1:0] ecyc;
        logic [DW-1:0] edat;
        do_reset;
        for (int s = 0; s < NS; s++) sdat_in[s*DW +: DW] = 32'hA000_0000 | 32'(s);
        set_m(0, 1'b1, 1'b1, 20'h0);
        tick;
        for (int i = 0; i < 6; i++) begin
            m_adr[AW-1:0] = dec_adr[i];
            ecyc = (dec_exp[i] < 0) ? '0 : NS'(1 << dec_exp[i]);
            edat = (dec_exp[i] < 0) ? '0 : (32'hA000_0000 | 32'(dec_exp[i]));
            #1;
            n_vec++;
            if ({s_cyc, mdat_out} !== {ecyc, edat}) begin
                n_err++; $display("FAIL decode_%0d: got %b/%h want %b/%h", i, s_cyc, mdat_out, ecyc, edat);
            end
            tick;
        end
        clear_inputs;
        tick;
    endtask

    task automatic test_rr;
        int exp;
        do_reset;
        s_ack[1] = 1'b1;
        for (int m = 0; m < NM; m++) set_m(m, 1'b1, 1'b1, 20'h10000 + AW'(m * 4));
        #1;
        n_vec++;
        if (grant !== 3'b000) begin
            n_err++; $display("FAIL rr_start: got %b want 000", grant);
        end
        tick;
        for (int r = 0; r < 4; r++) begin
            exp = r % NM;
            #1;
            n_vec++;
            if ({grant, m_ack} !== {NM'(1 << exp), NM'(1 << exp)}) begin
                n_err++; $display("FAIL rr_grant_%0d: got %b/%b want %b", r, grant, m_ack, NM'(1 << exp));
            end
            tick;
            set_m(exp, 1'b0, 1'b0, 20'h10000 + AW'(exp * 4));
            #1;
            n_vec++;
            if ({grant, m_ack} !== {NM'(1 << exp), 3'b000}) begin
                n_err++; $display("FAIL rr_drop_%0d: got %b/%b", r, grant, m_ack);
            end
            tick;
            set_m(exp, 1'b1, 1'b1, 20'h10000 + AW'(exp * 4));
            #1;
            n_vec++;
            if ({grant, m_ack} !== 6'b0) begin
                n_err++; $display("FAIL rr_dead_%0d: got %b/%b want 0", r, grant, m_ack);
            end
            tick;
        end
        clear_inputs;
        tick;
    endtask

    task automatic test_lock;
        do_reset;
        set_m(1, 1'b1, 1'b1, 20'h20004);
        tick;
        set_m(0, 1'b1, 1'b1, 20'h00020);
        for (int t = 0; t < 3; t++) begin
            s_ack[2] = 1'b1;
            #1;
            n_vec++;
            if ({grant, m_ack, s_adr} !== {3'b010, 3'b010, 20'h20004}) begin
                n_err++; $display("FAIL lock_xfer_%0d: got %b/%b/%h", t, grant, m_ack, s_adr);
            end
            tick;
            s_ack[2] = 1'b0;
            #1;
            n_vec++;
            if ({grant, m_ack} !== {3'b010, 3'b000}) begin
                n_err++; $display("FAIL lock_gap_%0d: got %b/%b", t, grant, m_ack);
            end
            tick;
        end
        set_m(1, 1'b0, 1'b0, 20'h0);
        #1;
        n_vec++;
        if (grant !== 3'b010) begin
            n_err++; $display("FAIL lock_release: got %b want 010", grant);
        end
        tick;
        #1;
        n_vec++;
        if (grant !== 3'b000) begin
            n_err++; $display("FAIL lock_dead: got %b want 000", grant);
        end
        tick;
        #1;
        n_vec++;
        if ({grant, s_cyc, s_adr} !== {3'b001, 4'b0001, 20'h00020}) begin
            n_err++; $display("FAIL lock_next: got %b/%b/%h", grant, s_cyc, s_adr);
        end
        clear_inputs;
        tick;
        tick;
    endtask

    task automatic test_unmapped;
        logic [NM-1:0] exp_err [4] = '{3'b000, 3'b000, 3'b001, 3'b000};
        do_reset;
        set_m(0, 1'b1, 1'b1, 20'hFFFFF);
        s_ack = '1;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) m_stb[0] = 1'b0;
            #1;
            n_vec++;
            if ({s_cyc, s_stb, m_ack} !== '0 || m_err !== ((c < 4) ? exp_err[c] : 3'b000)) begin
                n_err++; $display("FAIL unmapped_c%0d: err %b scyc %b sstb %b ack %b", c, m_err, s_cyc, s_stb, m_ack);
            end
            tick;
        end
        clear_inputs;
        tick;
        tick;
    endtask

    task automatic test_timeout;
        logic          et;
        logic [NS-1:0] es;
        do_reset;
        set_m(0, 1'b1, 1'b1, 20'h20000);
        tick;
        for (int i = 1; i <= 255; i++) begin
            et = (i == 255);
            es = et ? 4'b0000 : 4'b0100;
            #1;
            n_vec++;
            if ({tmo, m_err, s_stb} !== {et, et ? 3'b001 : 3'b000, es}) begin
                n_err++; $display("FAIL timeout_cycle_%0d: got %b want %b", i, {tmo, m_err, s_stb}, {et, et ? 3'b001 : 3'b000, es});
            end
            tick;
        end
        m_stb[0] = 1'b0;
        for (int i = 256; i <= 260; i++) begin
            if (i == 260) s_ack[2] = 1'b1;
            #1;
            n_vec++;
            if ({tmo, m_err, m_ack} !== 7'b0) begin
                n_err++; $display("FAIL timeout_after_%0d: got %b want 0", i, {tmo, m_err, m_ack});
            end
            tick;
        end
        clear_inputs;
        tick;
        tick;
    endtask

    task automatic test_priority_reset;
        do_reset;
        set_m(2, 1'b1, 1'b1, 20'h10008);
        tick;
        s_ack[1] = 1'b1; s_err[1] = 1'b1;
        #1;
        n_vec++;
        if ({m_err, m_ack, m_rty} !== {3'b100, 3'b000, 3'b000}) begin
            n_err++; $display("FAIL prio_err_over_ack: got %b", {m_err, m_ack, m_rty});
        end
        tick;
        s_err[1] = 1'b0; s_rty[1] = 1'b1;
        #1;
        n_vec++;
        if ({m_err, m_ack, m_rty} !== {3'b000, 3'b000, 3'b100}) begin
            n_err++; $display("FAIL prio_rty_over_ack: got %b", {m_err, m_ack, m_rty});
        end
        tick;
        s_rty[1] = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({grant, s_cyc, m_ack} !== {3'b100, 4'b0010, 3'b100}) begin
            n_err++; $display("FAIL rst_same_cycle: got %b", {grant, s_cyc, m_ack});
        end
        tick;
        #1;
        n_vec++;
        if ({grant, s_cyc, s_stb, m_ack} !== '0) begin
            n_err++; $display("FAIL rst_next_cycle: got %b want 0", {grant, s_cyc, s_stb, m_ack});
        end
        rst = 1'b0;
        clear_inputs;
        tick;
    endtask

    task automatic test_random;
        int            owner, last, cnt, tgt;
        bit            unm, unm_n, v, sa, se, sr, tfire, eerr, erty, eack;
        logic [NM-1:0] egrant;
        logic [NS-1:0] ecyc, estb;
        logic [DW-1:0] edat;
        logic [AW-1:0] eadr;
        do_reset;
        owner = -1; last = NM - 1; cnt = 0; unm = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int m = 0; m < NM; m++) begin
                if (m_cyc[m]) begin
                    if ($urandom_range(0, 5) == 0) m_cyc[m] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    m_cyc[m] = 1'b1;
                end
                m_stb[m] = m_cyc[m] && ($urandom_range(0, 2) != 0);
                m_we[m]  = 1'($urandom);
                if ($urandom_range(0, 3) == 0) m_adr[m*AW +: AW] = {4'($urandom_range(0, 7)), 16'($urandom)};
                m_dat[m*DW +: DW] = $urandom;
                m_sel[m*SW +: SW] = 4'($urandom);
            end
            for (int s = 0; s < NS; s++) begin
                s_ack[s] = ($urandom_range(0, 1) == 0);
                s_err[s] = ($urandom_range(0, 7) == 0);
                s_rty[s] = ($urandom_range(0, 7) == 0);
                sdat_in[s*DW +: DW] = $urandom;
            end
            #1;
            // Reference: owner's address decides the slave; responses ranked err > rty > ack
            egrant = (owner >= 0) ? NM'(1 << owner) : '0;
            tgt = -1; v = 1'b0; eadr = '0; sa = 1'b0; se = 1'b0; sr = 1'b0;
            if (owner >= 0) begin
                eadr = m_adr[owner*AW +: AW];
                if (m_cyc[owner]) tgt = ref_decode(eadr);
                v = (tgt >= 0) && m_stb[owner];
            end
            if (v) begin
                sa = s_ack[tgt]; se = s_err[tgt]; sr = s_rty[tgt];
            end
            tfire = v && !(sa || se || sr) && (cnt + 1 == TMO);
            eerr  = se || tfire || unm;
            erty  = !eerr && sr;
            eack  = !eerr && !erty && sa;
            ecyc  = (tgt >= 0) ? NS'(1 << tgt) : '0;
            estb  = (v && !tfire) ? ecyc : '0;
            edat  = (tgt >= 0) ? sdat_in[tgt*DW +: DW] : '0;
            n_vec++;
            if (grant !== egrant) begin
                n_err++; $display("FAIL rand_grant c%0d: got %b want %b", c, grant, egrant);
            end
            n_vec++;
            if ({m_ack, m_err, m_rty} !== {eack ? egrant : 3'b0, eerr ? egrant : 3'b0, erty ? egrant : 3'b0}) begin
                n_err++; $display("FAIL rand_resp c%0d: got %b want %b", c, {m_ack, m_err, m_rty},
                                  {eack ? egrant : 3'b0, eerr ? egrant : 3'b0, erty ? egrant : 3'b0});
            end
            n_vec++;
            if ({s_cyc, s_stb} !== {ecyc, estb}) begin
                n_err++; $display("FAIL rand_slave_sel c%0d: got %b want %b", c, {s_cyc, s_stb}, {ecyc, estb});
            end
            n_vec++;
            if (mdat_out !== edat) begin
                n_err++; $display("FAIL rand_rdata c%0d: got %h want %h", c, mdat_out, edat);
            end
            n_vec++;
            if (s_adr !== eadr) begin
                n_err++; $display("FAIL rand_adr c%0d: got %h want %h", c, s_adr, eadr);
            end
            n_vec++;
            if (tmo !== tfire) begin
                n_err++; $display("FAIL rand_timeout c%0d: got %b want %b", c, tmo, tfire);
            end
            // Advance the reference across the clock edge
            if (rst) begin
                owner = -1; last = NM - 1; cnt = 0; unm = 1'b0;
            end else begin
                unm_n = (owner >= 0) && m_cyc[owner] && m_stb[owner] && (tgt < 0) && !unm;
                cnt   = (v && !(sa || se || sr) && !tfire) ? cnt + 1 : 0;
                unm   = unm_n;
                if (owner < 0) begin
                    for (int k = 1; k <= NM; k++) begin
                        if (owner < 0 && m_cyc[(last + k) % NM]) owner = (last + k) % NM;
                    end
                    if (owner >= 0) last = owner;
                end else if (!m_cyc[owner]) begin
                    owner = -1;
                end
            end
            tick;
        end
        rst = 1'b0;
        clear_inputs;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        clear_inputs;
        test_reset;
        test_single;
        test_decode;
        test_rr;
        test_lock;
        test_unmapped;
        test_timeout;
        test_priority_reset;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
